// File: rtl/aemb2_ifill_pkg.sv
// Shared definitions for the AEMB2 instruction-cache refill sequencer.
package aemb2_ifill_pkg;

  typedef enum logic [1:0] {
    IFL_IDLE = 2'd0,
    IFL_FILL = 2'd1,
    IFL_SETL = 2'd2
  } ifl_state_t;

  localparam logic [3:0] IWB_SEL_WORD = 4'hF;

endpackage

// File: rtl/aemb2_ifill.sv
// AEMB2 instruction-cache refill sequencer: stalls fetch on a miss and reads one line over IWB.
// Define AEMB_ICH_CWF_EN to fetch the critical word first (wrapping burst order).
module aemb2_ifill
  import aemb2_ifill_pkg::*;
#(
  parameter int AEMB_IWB = 32,
  parameter int AEMB_ICH = 11,
  parameter int AEMB_IDX = 6
) (
  input  logic                gclk,
  input  logic                grst,
  input  logic                fet_req,
  input  logic [AEMB_IWB-1:2] fet_adr,
  input  logic                ich_hit,
  output logic [AEMB_IWB-1:2] ich_adr,
  output logic                ich_stl,
  output logic [AEMB_IWB-1:2] iwb_adr_o,
  output logic                iwb_cyc_o,
  output logic                iwb_stb_o,
  output logic [3:0]          iwb_sel_o,
  output logic                iwb_wre_o,
  input  logic                iwb_ack_i
);

  localparam int LNE = AEMB_IDX - 2;
  localparam int VAL = 1 << LNE;
  localparam int BSW = AEMB_IWB - AEMB_IDX;
  localparam logic [LNE:0] DONE_LAST = (LNE + 1)'(VAL - 1);

  // A line must fit in the cache and hold between 2 and 16 words.
  if (AEMB_ICH < AEMB_IDX || AEMB_IDX < 3 || AEMB_IDX > 6) begin : g_bad_geometry
    $error("aemb2_ifill: unsupported cache/line geometry");
  end

  ifl_state_t     state;
  ifl_state_t     state_nxt;
  logic [BSW-1:0] base;
  logic [LNE-1:0] cnt;
  logic [LNE-1:0] start;
  logic [LNE:0]   done;
  logic           miss;
  logic           load;
  logic           adv;

`ifdef AEMB_ICH_CWF_EN
  assign start = fet_adr[AEMB_IDX-1:2];
`else
  assign start = '0;
`endif

  // Reset gates the miss so the pipeline is never stalled while the core is held in reset.
  assign miss = fet_req & ~ich_hit & grst;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    adv       = 1'b0;
    ich_stl   = 1'b0;
    ich_adr   = fet_adr;
    case (state)
      IFL_IDLE: begin
        ich_stl = miss;
        if (miss) begin
          load      = 1'b1;
          state_nxt = IFL_FILL;
        end
      end
      IFL_FILL: begin
        ich_stl = 1'b1;
        ich_adr = iwb_adr_o;
        if (iwb_ack_i) begin
          adv = 1'b1;
          if (done == DONE_LAST) state_nxt = IFL_SETL;
        end
      end
      IFL_SETL: begin
        ich_stl   = 1'b1;
        state_nxt = IFL_IDLE;
      end
      default: state_nxt = IFL_IDLE;
    endcase
  end

  always_ff @(posedge gclk or negedge grst) begin
    if (!grst) begin
      state <= IFL_IDLE;
      base  <= '0;
      cnt   <= '0;
      done  <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        base <= fet_adr[AEMB_IWB-1:AEMB_IDX];
        cnt  <= start;
        done <= '0;
      end else if (adv) begin
        cnt  <= cnt + 1'b1;
        done <= done + 1'b1;
      end
    end
  end

  // Bus controls decode straight from the state register, so reset drops them at once.
  assign iwb_cyc_o = (state == IFL_FILL);
  assign iwb_stb_o = iwb_cyc_o;
  assign iwb_sel_o = iwb_cyc_o ? IWB_SEL_WORD : 4'h0;
  assign iwb_wre_o = 1'b0;
  assign iwb_adr_o = {base, cnt};

endmodule

// File: tb/tb_aemb2_ifill.sv
// Randomised self-checking bench for aemb2_ifill; the expected fill order comes from line arithmetic.
module tb_aemb2_ifill;

  localparam int IWB = 32;
  localparam int ICH = 11;
  localparam int IDX = 6;
  localparam int LNE = IDX - 2;
  localparam int VAL = 1 << LNE;

  logic           gclk = 1'b0;
  logic           grst;
  logic           fet_req;
  logic [IWB-1:2] fet_adr;
  logic           ich_hit;
  logic [IWB-1:2] ich_adr;
  logic           ich_stl;
  logic [IWB-1:2] iwb_adr_o;
  logic           iwb_cyc_o;
  logic           iwb_stb_o;
  logic [3:0]     iwb_sel_o;
  logic           iwb_wre_o;
  logic           iwb_ack_i;

  int errors = 0;
  int checks = 0;

  always #5 gclk = ~gclk;

  aemb2_ifill #(
    .AEMB_IWB(IWB),
    .AEMB_ICH(ICH),
    .AEMB_IDX(IDX)
  ) dut (
    .gclk     (gclk),
    .grst     (grst),
    .fet_req  (fet_req),
    .fet_adr  (fet_adr),
    .ich_hit  (ich_hit),
    .ich_adr  (ich_adr),
    .ich_stl  (ich_stl),
    .iwb_adr_o(iwb_adr_o),
    .iwb_cyc_o(iwb_cyc_o),
    .iwb_stb_o(iwb_stb_o),
    .iwb_sel_o(iwb_sel_o),
    .iwb_wre_o(iwb_wre_o),
    .iwb_ack_i(iwb_ack_i)
  );

  // Word within the line that the burst begins with.
  function automatic int start_word(input logic [IWB-1:2] a);
`ifdef AEMB_ICH_CWF_EN
    return int'(a % VAL);
`else
    return 0;
`endif
  endfunction

  // Drive one complete miss/refill from an IDLE negedge; returns at the first IDLE negedge after SETL.
  task automatic run_fill(input logic [IWB-1:2] a, input int waits, input int abort_after,
                          input logic end_hit);
    logic [IWB-1:2] line_base;
    logic [IWB-1:2] exp;
    int s;
    line_base = a - (a % VAL);
    s = start_word(a);
    fet_req = 1'b1;
    fet_adr = a;
    ich_hit = 1'b0;
    iwb_ack_i = 1'b0;
    #1;
    checks++;
    if (ich_stl !== 1'b1 || iwb_cyc_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL miss_detect stl=%b cyc=%b expected stl=1 cyc=0", ich_stl, iwb_cyc_o);
    end
    checks++;
    if (ich_adr !== a) begin
      errors++;
      $display("[TB] FAIL idle_adr got=%h expected=%h", ich_adr, a);
    end
    @(posedge gclk);
    @(negedge gclk);
    for (int k = 0; k < VAL; k++) begin
      for (int w = 0; w <= waits; w++) begin
        exp = line_base + (IWB-2)'((s + k) % VAL);
        ich_hit = 1'($urandom);
        fet_adr = (IWB-2)'($urandom);
        #1;
        checks++;
        if ({iwb_cyc_o, iwb_stb_o, iwb_sel_o, iwb_wre_o, ich_stl} !== {1'b1, 1'b1, 4'hF, 1'b0, 1'b1}) begin
          errors++;
          $display("[TB] FAIL fill_ctl k=%0d w=%0d cyc=%b stb=%b sel=%h wre=%b stl=%b expected 1 1 f 0 1",
                   k, w, iwb_cyc_o, iwb_stb_o, iwb_sel_o, iwb_wre_o, ich_stl);
        end
        checks++;
        if (iwb_adr_o !== exp || ich_adr !== exp) begin
          errors++;
          $display("[TB] FAIL fill_adr k=%0d bus=%h cache=%h expected=%h", k, {iwb_adr_o, 2'b00},
                   {ich_adr, 2'b00}, {exp, 2'b00});
        end
        iwb_ack_i = (w == waits);
        @(posedge gclk);
        @(negedge gclk);
      end
      if (abort_after == k + 1) begin
        iwb_ack_i = 1'b0;
        fet_req = 1'b1;
        ich_hit = 1'b0;
        grst = 1'b0;
        #1;
        checks++;
        if ({iwb_cyc_o, iwb_stb_o, iwb_sel_o, ich_stl} !== 7'b0) begin
          errors++;
          $display("[TB] FAIL abort cyc=%b stb=%b sel=%h stl=%b expected all zero", iwb_cyc_o,
                   iwb_stb_o, iwb_sel_o, ich_stl);
        end
        @(posedge gclk);
        @(negedge gclk);
        grst = 1'b1;
        return;
      end
    end
    iwb_ack_i = 1'($urandom);
    fet_adr = a;
    ich_hit = 1'($urandom);
    #1;
    checks++;
    if ({iwb_cyc_o, iwb_stb_o, iwb_sel_o, ich_stl} !== {1'b0, 1'b0, 4'h0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL settle cyc=%b stb=%b sel=%h stl=%b expected 0 0 0 1", iwb_cyc_o,
               iwb_stb_o, iwb_sel_o, ich_stl);
    end
    checks++;
    if (ich_adr !== a) begin
      errors++;
      $display("[TB] FAIL settle_adr got=%h expected=%h", ich_adr, a);
    end
    @(posedge gclk);
    @(negedge gclk);
    iwb_ack_i = 1'b0;
    ich_hit = end_hit;
    #1;
    checks++;
    if (ich_stl !== !end_hit || iwb_cyc_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reeval stl=%b cyc=%b expected stl=%b cyc=0", ich_stl, iwb_cyc_o, !end_hit);
    end
  endtask

  task automatic test_reset();
    grst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fet_req = 1'($urandom);
      ich_hit = 1'($urandom);
      fet_adr = (IWB-2)'($urandom);
      iwb_ack_i = 1'($urandom);
      @(negedge gclk);
      #1;
      checks++;
      if ({iwb_cyc_o, iwb_stb_o, iwb_sel_o, ich_stl} !== 7'b0) begin
        errors++;
        $display("[TB] FAIL reset_out cyc=%b stb=%b sel=%h stl=%b expected all zero", iwb_cyc_o,
                 iwb_stb_o, iwb_sel_o, ich_stl);
      end
    end
    iwb_ack_i = 1'b0;
    fet_req = 1'b0;
    grst = 1'b1;
    @(negedge gclk);
    #1;
    checks++;
    if (iwb_cyc_o !== 1'b0 || ich_stl !== 1'b0 || ich_adr !== fet_adr) begin
      errors++;
      $display("[TB] FAIL reset_release cyc=%b stl=%b adr=%h expected 0 0 %h", iwb_cyc_o, ich_stl,
               ich_adr, fet_adr);
    end
  endtask

  task automatic test_no_wait();
    run_fill(30'h0040_0005, 0, 0, 1'b1);
    fet_req = 1'b0;
  endtask

  task automatic test_wait_states();
    run_fill((IWB-2)'($urandom), 3, 0, 1'b1);
    fet_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [IWB-1:2] a;
    a = (IWB-2)'($urandom);
    run_fill(a, 0, 0, 1'b0);
    run_fill(a, 1, 0, 1'b1);
    fet_req = 1'b0;
  endtask

  task automatic test_abort();
    logic [IWB-1:2] a;
    a = 30'h0040_0005;
    run_fill(a, 0, 7, 1'b1);
    run_fill(a - (a % VAL) + 30'd8, 0, 0, 1'b1);
    fet_req = 1'b0;
  endtask

  task automatic test_hit();
    for (int i = 0; i < 10; i++) begin
      @(negedge gclk);
      fet_req = 1'($urandom);
      ich_hit = fet_req ? 1'b1 : 1'($urandom);
      fet_adr = (IWB-2)'($urandom);
      iwb_ack_i = 1'($urandom);
      #1;
      checks++;
      if (ich_stl !== 1'b0 || iwb_cyc_o !== 1'b0 || ich_adr !== fet_adr) begin
        errors++;
        $display("[TB] FAIL hit_idle stl=%b cyc=%b adr=%h expected 0 0 %h", ich_stl, iwb_cyc_o,
                 ich_adr, fet_adr);
      end
    end
    @(negedge gclk);
    iwb_ack_i = 1'b0;
    fet_req = 1'b0;
    #1;
    checks++;
    if (iwb_cyc_o !== 1'b0 || iwb_stb_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL spurious_ack cyc=%b stb=%b expected 0 0", iwb_cyc_o, iwb_stb_o);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3; i++) begin
      run_fill((IWB-2)'($urandom), int'($urandom_range(0, 2)), 0, 1'b1);
      fet_req = 1'b0;
      @(negedge gclk);
    end
  endtask

  initial begin
    grst = 1'b0;
    fet_req = 1'b0;
    fet_adr = '0;
    ich_hit = 1'b0;
    iwb_ack_i = 1'b0;
    @(negedge gclk);
    test_reset();
    test_no_wait();
    test_wait_states();
    test_back_to_back();
    test_abort();
    test_hit();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
